// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and encodings for the ID/EX operand stage.
// Forwarding source codes, operand selects and the EX control bundle.
package id_ex_operand_stage_pkg;

  localparam logic [1:0] XLEN_32B = 2'd1;
  localparam logic [1:0] XLEN_64B = 2'd2;

  localparam logic [1:0] FWD_SRC_REG = 2'd0;
  localparam logic [1:0] FWD_SRC_EXM = 2'd1;
  localparam logic [1:0] FWD_SRC_MWB = 2'd2;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_SHF  = 3'd7
  } alu_ctl_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       src_a_sel;
    logic       src_b_sel;
    logic [2:0] alu_op;
    logic [1:0] alu_shift;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ex_ctrl_t;

  function automatic logic fwd_hit(
    input logic       vld,
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return vld & we & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand bypass select: EX/MEM over MEM/WB over register file.
// x0 is never bypassed.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   i_rs,
  input  logic [W-1:0] i_rf_data,
  input  logic         i_exm_valid,
  input  logic         i_exm_reg_write,
  input  logic [4:0]   i_exm_rd,
  input  logic [W-1:0] i_exm_data,
  input  logic         i_mwb_valid,
  input  logic         i_mwb_reg_write,
  input  logic [4:0]   i_mwb_rd,
  input  logic [W-1:0] i_mwb_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_src
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = fwd_hit(i_exm_valid, i_exm_reg_write,
                           i_exm_rd, i_rs);
  assign mwb_hit = fwd_hit(i_mwb_valid, i_mwb_reg_write,
                           i_mwb_rd, i_rs);

  always_comb begin
    o_data = i_rf_data;
    o_src  = FWD_SRC_REG;
    unique case (1'b1)
      exm_hit: begin
        o_data = i_exm_data;
        o_src  = FWD_SRC_EXM;
      end
      (!exm_hit && mwb_hit): begin
        o_data = i_mwb_data;
        o_src  = FWD_SRC_MWB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypass and load-use bubble.
// Drives ALU operands and EX control from registered decode fields.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter logic [1:0] XLEN = XLEN_32B,
  localparam int W = 1 << (int'(XLEN) + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic         i_id_valid,
  input  logic [4:0]   i_id_rs1,
  input  logic [4:0]   i_id_rs2,
  input  logic [4:0]   i_id_rd,
  input  logic [W-1:0] i_id_rs1_data,
  input  logic [W-1:0] i_id_rs2_data,
  input  logic [W-1:0] i_id_imm,
  input  logic [W-1:0] i_id_pc,
  input  logic         i_id_src_a_sel,
  input  logic         i_id_src_b_sel,
  input  logic [2:0]   i_id_alu_op,
  input  logic [1:0]   i_id_alu_shift,
  input  logic         i_id_reg_write,
  input  logic         i_id_mem_read,
  input  logic         i_id_mem_write,
  input  logic         i_exm_valid,
  input  logic         i_exm_reg_write,
  input  logic [4:0]   i_exm_rd,
  input  logic [W-1:0] i_exm_alu_out,
  input  logic         i_mwb_valid,
  input  logic         i_mwb_reg_write,
  input  logic [4:0]   i_mwb_rd,
  input  logic [W-1:0] i_mwb_result,
  output logic [W-1:0] o_op_a,
  output logic [W-1:0] o_op_b,
  output logic [2:0]   o_alu_op,
  output logic [1:0]   o_alu_shift,
  output logic [W-1:0] o_store_data,
  output logic         o_ex_valid,
  output logic         o_ex_reg_write,
  output logic         o_ex_mem_read,
  output logic         o_ex_mem_write,
  output logic [4:0]   o_ex_rd,
  output logic         o_load_use_stall
);

  ex_ctrl_t ctrl_q, ctrl_d, id_ctrl;

  logic [W-1:0] rs1_data_q, rs1_data_d;
  logic [W-1:0] rs2_data_q, rs2_data_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] pc_q, pc_d;

  logic [W-1:0] rs1_fwd, rs2_fwd;
  logic [1:0]   rs1_src, rs2_src;
  logic [3:0]   unused_fwd_src;

  logic load_use;
  logic load_bubble;
  logic hold;

  assign id_ctrl = {i_id_valid, i_id_rs1, i_id_rs2, i_id_rd,
                    i_id_src_a_sel, i_id_src_b_sel,
                    i_id_alu_op, i_id_alu_shift,
                    i_id_reg_write, i_id_mem_read,
                    i_id_mem_write};

  // Conservative: rs2 compared even when operand B is the immediate.
  assign load_use = ctrl_q.valid & ctrl_q.mem_read
                  & (ctrl_q.rd != 5'd0) & i_id_valid
                  & ((ctrl_q.rd == i_id_rs1)
                  |  (ctrl_q.rd == i_id_rs2));

  assign load_bubble = i_flush | (!i_stall & load_use);
  assign hold        = !i_flush & i_stall;

  always_comb begin
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    unique case (1'b1)
      load_bubble: begin
        ctrl_d     = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        pc_d       = '0;
      end
      hold: ;
      default: begin
        ctrl_d     = id_ctrl;
        rs1_data_d = i_id_rs1_data;
        rs2_data_d = i_id_rs2_data;
        imm_d      = i_id_imm;
        pc_d       = i_id_pc;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
    end
  end

  id_ex_operand_stage_fwd_mux #(.W(W)) u_fwd_rs1 (
    .i_rs            (ctrl_q.rs1),
    .i_rf_data       (rs1_data_q),
    .i_exm_valid     (i_exm_valid),
    .i_exm_reg_write (i_exm_reg_write),
    .i_exm_rd        (i_exm_rd),
    .i_exm_data      (i_exm_alu_out),
    .i_mwb_valid     (i_mwb_valid),
    .i_mwb_reg_write (i_mwb_reg_write),
    .i_mwb_rd        (i_mwb_rd),
    .i_mwb_data      (i_mwb_result),
    .o_data          (rs1_fwd),
    .o_src           (rs1_src)
  );

  id_ex_operand_stage_fwd_mux #(.W(W)) u_fwd_rs2 (
    .i_rs            (ctrl_q.rs2),
    .i_rf_data       (rs2_data_q),
    .i_exm_valid     (i_exm_valid),
    .i_exm_reg_write (i_exm_reg_write),
    .i_exm_rd        (i_exm_rd),
    .i_exm_data      (i_exm_alu_out),
    .i_mwb_valid     (i_mwb_valid),
    .i_mwb_reg_write (i_mwb_reg_write),
    .i_mwb_rd        (i_mwb_rd),
    .i_mwb_data      (i_mwb_result),
    .o_data          (rs2_fwd),
    .o_src           (rs2_src)
  );

  // Source codes are kept for debug visibility only.
  assign unused_fwd_src = {rs1_src, rs2_src};

  assign o_op_a = !ctrl_q.valid ? '0
                : (ctrl_q.src_a_sel == SRC_A_PC) ? pc_q
                : rs1_fwd;
  assign o_op_b = !ctrl_q.valid ? '0
                : (ctrl_q.src_b_sel == SRC_B_IMM) ? imm_q
                : rs2_fwd;
  assign o_store_data = ctrl_q.valid ? rs2_fwd : '0;

  assign o_alu_op         = ctrl_q.alu_op;
  assign o_alu_shift      = ctrl_q.alu_shift;
  assign o_ex_valid       = ctrl_q.valid;
  assign o_ex_reg_write   = ctrl_q.reg_write;
  assign o_ex_mem_read    = ctrl_q.mem_read;
  assign o_ex_mem_write   = ctrl_q.mem_write;
  assign o_ex_rd          = ctrl_q.rd;
  assign o_load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and random checks of id_ex_operand_stage against a
// behavioural model of the EX slot contents.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall, flush;
  logic         id_valid;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic [W-1:0] id_d1, id_d2, id_imm, id_pc;
  logic         id_sa, id_sb;
  logic [2:0]   id_op;
  logic [1:0]   id_sh;
  logic         id_rw, id_mr, id_mw;
  logic         exm_v, exm_we;
  logic [4:0]   exm_rd;
  logic [W-1:0] exm_val;
  logic         mwb_v, mwb_we;
  logic [4:0]   mwb_rd;
  logic [W-1:0] mwb_val;

  logic [W-1:0] op_a, op_b, st_data;
  logic [2:0]   alu_op;
  logic [1:0]   alu_sh;
  logic         ex_v, ex_rw, ex_mr, ex_mw, lu_stall;
  logic [4:0]   ex_rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         v;
    bit [4:0]   rs1, rs2, rd;
    bit [W-1:0] d1, d2, imm, pc;
    bit         sa, sb;
    bit [2:0]   op;
    bit [1:0]   sh;
    bit         rw, mr, mw;
  } slot_t;

  slot_t m;
  slot_t empty_slot;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN_32B)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_id_valid       (id_valid),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_rd          (id_rd),
    .i_id_rs1_data    (id_d1),
    .i_id_rs2_data    (id_d2),
    .i_id_imm         (id_imm),
    .i_id_pc          (id_pc),
    .i_id_src_a_sel   (id_sa),
    .i_id_src_b_sel   (id_sb),
    .i_id_alu_op      (id_op),
    .i_id_alu_shift   (id_sh),
    .i_id_reg_write   (id_rw),
    .i_id_mem_read    (id_mr),
    .i_id_mem_write   (id_mw),
    .i_exm_valid      (exm_v),
    .i_exm_reg_write  (exm_we),
    .i_exm_rd         (exm_rd),
    .i_exm_alu_out    (exm_val),
    .i_mwb_valid      (mwb_v),
    .i_mwb_reg_write  (mwb_we),
    .i_mwb_rd         (mwb_rd),
    .i_mwb_result     (mwb_val),
    .o_op_a           (op_a),
    .o_op_b           (op_b),
    .o_alu_op         (alu_op),
    .o_alu_shift      (alu_sh),
    .o_store_data     (st_data),
    .o_ex_valid       (ex_v),
    .o_ex_reg_write   (ex_rw),
    .o_ex_mem_read    (ex_mr),
    .o_ex_mem_write   (ex_mw),
    .o_ex_rd          (ex_rd),
    .o_load_use_stall (lu_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [W-1:0] fwd(input bit [4:0] rs,
                                     input bit [W-1:0] rf);
    if (rs != 0 && exm_v && exm_we && exm_rd == rs) return exm_val;
    if (rs != 0 && mwb_v && mwb_we && mwb_rd == rs) return mwb_val;
    return rf;
  endfunction

  function automatic bit hazard();
    return m.v && m.mr && m.rd != 0 && id_valid
        && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic check_all();
    bit [W-1:0] f1, f2;
    f1 = fwd(m.rs1, m.d1);
    f2 = fwd(m.rs2, m.d2);
    check("op_a", op_a, !m.v ? 0 : (m.sa ? m.pc : f1));
    check("op_b", op_b, !m.v ? 0 : (m.sb ? m.imm : f2));
    check("store_data", st_data, m.v ? f2 : 0);
    check("alu_op", alu_op, m.op);
    check("alu_shift", alu_sh, m.sh);
    check("ex_valid", ex_v, m.v);
    check("ex_reg_write", ex_rw, m.rw);
    check("ex_mem_read", ex_mr, m.mr);
    check("ex_mem_write", ex_mw, m.mw);
    check("ex_rd", ex_rd, m.rd);
    check("load_use", lu_stall, hazard());
  endtask

  // Check at negedge, then advance the model and DUT one edge.
  task automatic cycle();
    slot_t nxt;
    @(negedge clk);
    check_all();
    if (flush) nxt = empty_slot;
    else if (stall) nxt = m;
    else if (hazard()) nxt = empty_slot;
    else begin
      nxt.v = id_valid; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
      nxt.rd = id_rd; nxt.d1 = id_d1; nxt.d2 = id_d2;
      nxt.imm = id_imm; nxt.pc = id_pc; nxt.sa = id_sa;
      nxt.sb = id_sb; nxt.op = id_op; nxt.sh = id_sh;
      nxt.rw = id_rw; nxt.mr = id_mr; nxt.mw = id_mw;
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_d1 = 0; id_d2 = 0; id_imm = 0; id_pc = 0;
    id_sa = 0; id_sb = 0; id_op = 0; id_sh = 0;
    id_rw = 0; id_mr = 0; id_mw = 0;
  endtask

  task automatic idle_fwd();
    exm_v = 0; exm_we = 0; exm_rd = 0; exm_val = 0;
    mwb_v = 0; mwb_we = 0; mwb_rd = 0; mwb_val = 0;
  endtask

  task automatic set_id(input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [W-1:0] d1,
                        input bit [W-1:0] d2, input bit mr);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_d1 = d1; id_d2 = d2; id_imm = 32'h100; id_pc = 32'h8000;
    id_sa = SRC_A_RS1; id_sb = SRC_B_RS2;
    id_op = ALU_ADD; id_sh = 0;
    id_rw = 1; id_mr = mr; id_mw = 0;
  endtask

  initial begin
    empty_slot = '{default: 0};
    m = empty_slot;
    rst = 1; stall = 0; flush = 0;
    idle_id();
    idle_fwd();
    @(posedge clk);
    #1;
    check("rst ex_valid", ex_v, 0);
    check("rst alu_op", alu_op, 0);
    check("rst op_a", op_a, 0);
    check("rst load_use", lu_stall, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Plain capture
    set_id(1, 2, 3, 5, 7, 0);
    cycle();
    check("cap op_a", op_a, 5);
    check("cap op_b", op_b, 7);
    check("cap valid", ex_v, 1);

    // Double forward, EX/MEM priority
    set_id(3, 4, 8, 32'h11, 32'h22, 0);
    cycle();
    idle_id();
    exm_v = 1; exm_we = 1; exm_rd = 3; exm_val = 32'hAA;
    mwb_v = 1; mwb_we = 1; mwb_rd = 3; mwb_val = 32'hBB;
    #1 check("fwd exm prio", op_a, 32'hAA);
    exm_v = 0;
    #1 check("fwd mwb", op_a, 32'hBB);
    cycle();
    idle_fwd();

    // x0 never forwarded
    set_id(1, 0, 9, 32'h3, 32'h0, 0);
    cycle();
    exm_v = 1; exm_we = 1; exm_rd = 0; exm_val = 32'hFF;
    #1 check("x0 op_b", op_b, 0);
    check("x0 store", st_data, 0);
    cycle();
    idle_fwd();

    // Load-use bubble
    set_id(1, 2, 5, 32'h40, 0, 1);
    cycle();
    set_id(5, 0, 6, 32'h1234, 0, 0);
    #1 check("lu stall", lu_stall, 1);
    cycle();
    check("lu bubble", ex_v, 0);
    check("lu released", lu_stall, 0);
    exm_v = 1; exm_we = 1; exm_rd = 5; exm_val = 32'h40;
    cycle();
    exm_v = 0; exm_rd = 0;
    mwb_v = 1; mwb_we = 1; mwb_rd = 5; mwb_val = 32'hCAFE;
    #1 check("lu consumer", op_a, 32'hCAFE);
    check("lu consumer v", ex_v, 1);

    // Stall holds, flush beats stall
    set_id(7, 7, 7, 32'h77, 32'h77, 0);
    stall = 1;
    cycle();
    check("stall hold op_a", op_a, 32'hCAFE);
    check("stall hold rd", ex_rd, 6);
    flush = 1;
    cycle();
    check("flush valid", ex_v, 0);
    check("flush rw", ex_rw, 0);
    check("flush rd", ex_rd, 0);
    stall = 0; flush = 0;
    idle_fwd();

    // Stall during load-use keeps the hazard asserted
    set_id(1, 2, 10, 0, 0, 1);
    cycle();
    set_id(3, 10, 11, 0, 0, 0);
    stall = 1;
    cycle();
    check("stall lu held", lu_stall, 1);
    check("stall lu mr", ex_mr, 1);
    stall = 0;
    cycle();
    cycle();

    // Asynchronous reset between edges
    set_id(2, 3, 12, 32'h9, 32'hA, 0);
    cycle();
    check("pre rst valid", ex_v, 1);
    #2 rst = 1;
    #1;
    m = empty_slot;
    check("arst valid", ex_v, 0);
    check("arst op_a", op_a, 0);
    check("arst rd", ex_rd, 0);
    check("arst rw", ex_rw, 0);
    #2 rst = 0;
    idle_id();
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rd  = 5'($urandom_range(0, 3));
      id_d1 = $urandom; id_d2 = $urandom;
      id_imm = $urandom; id_pc = $urandom;
      id_sa = 1'($urandom_range(0, 1));
      id_sb = 1'($urandom_range(0, 1));
      id_op = 3'($urandom_range(0, 7));
      id_sh = 2'($urandom_range(0, 3));
      id_rw = 1'($urandom_range(0, 1));
      id_mr = ($urandom_range(0, 2) == 0);
      id_mw = 1'($urandom_range(0, 1));
      exm_v = 1'($urandom_range(0, 1));
      exm_we = 1'($urandom_range(0, 1));
      exm_rd = 5'($urandom_range(0, 3));
      exm_val = $urandom;
      mwb_v = 1'($urandom_range(0, 1));
      mwb_we = 1'($urandom_range(0, 1));
      mwb_rd = 5'($urandom_range(0, 3));
      mwb_val = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline boundary that registers decoded instruction fields and drives the ALU operand and control inputs in EX. It sits directly upstream of the main ALU. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It detects load-use hazards, inserts a one-cycle bubble and holds the decode stage. It honours downstream stall and branch-flush requests.

## Interface
- XLEN, `XLEN_64b: 2-bit width code; W = 1<<(XLEN+4) (32b code gives 32, 64b code gives 64)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_stall  in  1  downstream hold; EX contents frozen
- i_flush  in  1  branch/trap flush; next EX slot becomes a bubble
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_rs1, i_id_rs2, i_id_rd  in  5 each  register indices
- i_id_rs1_data, i_id_rs2_data, i_id_imm, i_id_pc  in  W each  decode-stage values
- i_id_src_a_sel  in  1  operand A source: 0 = rs1, 1 = pc
- i_id_src_b_sel  in  1  operand B source: 0 = rs2, 1 = imm
- i_id_alu_op  in  3  ALU_CTL code
- i_id_alu_shift  in  2  ALU_SHIFT code
- i_id_reg_write, i_id_mem_read, i_id_mem_write  in  1 each  control bits
- i_exm_valid, i_exm_reg_write  in  1 each  EX/MEM producer qualifiers
- i_exm_rd  in  5  EX/MEM destination index
- i_exm_alu_out  in  W  EX/MEM result
- i_mwb_valid, i_mwb_reg_write  in  1 each  MEM/WB producer qualifiers
- i_mwb_rd  in  5  MEM/WB destination index
- i_mwb_result  in  W  MEM/WB result
- o_op_a, o_op_b  out  W each  ALU operands
- o_alu_op  out  3  registered ALU op
- o_alu_shift  out  2  registered shift select
- o_store_data  out  W  forwarded rs2 value, for stores
- o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write  out  1 each  registered control
- o_ex_rd  out  5  registered destination
- o_load_use_stall  out  1  hold request to IF/ID

## Operation
- Register update priority on each rising edge, highest first:
  - i_flush: load a bubble.
  - i_stall: hold current contents.
  - o_load_use_stall: load a bubble.
  - Otherwise: capture all i_id_* fields.
- A bubble sets every register to 0, which gives o_ex_valid=0 and clears all control bits.
- If i_id_valid=0, the stage still captures, so valid=0 propagates.
- Forwarding for rs1 and for rs2 is evaluated separately:
  - EX/MEM is selected if i_exm_valid & i_exm_reg_write & i_exm_rd!=0 & i_exm_rd==ex_rsN.
  - Otherwise MEM/WB is selected under the same conditions on the mwb_* signals.
  - Otherwise the registered register-file data is used.
  - EX/MEM wins when both stages match. Index x0 is never forwarded.
- Operand A is the registered pc if src_a_sel=1, else forwarded rs1.
- Operand B is the registered imm if src_b_sel=1, else forwarded rs2.
- o_store_data is always forwarded rs2.
- o_op_a, o_op_b and o_store_data are forced to 0 when o_ex_valid=0.
- o_load_use_stall = o_ex_valid & o_ex_mem_read & o_ex_rd!=0 & i_id_valid & (o_ex_rd==i_id_rs1 | o_ex_rd==i_id_rs2).
  - The rs2 comparison applies even when src_b_sel=1. This is deliberately conservative.
- i_flush masks nothing combinationally. It only affects the next register load.

## Timing
- Reset, asynchronous: every register and every output goes to 0, including o_alu_op=0 and o_load_use_stall=0.
- Latency: one cycle from ID inputs to the registered fields.
- Forwarding muxes and o_load_use_stall are combinational from current-cycle inputs and registered state. There is no extra latency.
- A load-use hazard costs exactly one bubble cycle:
  - Cycle N: the load is in EX. o_load_use_stall=1 and the bubble is captured.
  - Cycle N+1: the load is in MEM and the stall is deasserted. The consumer is captured at the next edge.
  - Cycle N+2: the consumer is in EX and forwards the load data from MEM/WB.
- i_stall together with a load-use hazard: hold. The hazard persists, and o_load_use_stall stays asserted while held.
- i_flush together with i_stall: flush wins.
- Reset asserted mid-pipeline clears the stage immediately, with no dependence on the clock.

## Structure
- Add to riscv_defines.vh:
  - `FWD_SRC_REG`, `FWD_SRC_EXM`, `FWD_SRC_MWB` (2-bit)
  - `SRC_A_RS1`, `SRC_A_PC`, `SRC_B_RS2`, `SRC_B_IMM`
- One sub-module, fwd_mux: takes a register index, the register-file data and both producer tuples; outputs the selected value and the 2-bit source code. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Plain capture. Stimulus: ID rs1_data=5, rs2_data=7, alu_op=ADD, both sel=0, no hazards. Required: next cycle o_op_a=5, o_op_b=7, o_ex_valid=1.
- Double forward, EX/MEM priority. Stimulus: ex_rs1=3, EX/MEM rd=3 with value 0xAA, MEM/WB rd=3 with value 0xBB. Required: o_op_a=0xAA. Then drop i_exm_valid. Required: o_op_a=0xBB.
- x0 not forwarded. Stimulus: ex_rs2=0, EX/MEM rd=0 with value 0xFF, rs2_data=0. Required: o_op_b=0.
- Load-use bubble. Stimulus: `lw x5` in EX, consumer with rs1=5 in ID. Required: o_load_use_stall=1 for one cycle. Next cycle o_ex_valid=0. The cycle after, the consumer is in EX with the MEM/WB value forwarded.
- Stall/flush priority. Stimulus: i_stall=1 with new ID data. Required: outputs unchanged. Then i_stall=1 and i_flush=1. Required: next cycle o_ex_valid=0 and all controls 0.
- Async reset. Stimulus: assert i_rst between clock edges while o_ex_valid=1. Required: all outputs go to 0 before the next edge.
